// File: rtl/serial_div_pkg.sv
// Shared types and sizing helpers for the serial restoring divider.
package serial_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 1024;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step
  import serial_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {r, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  // The partial remainder stays below the divisor, so its low WIDTH bits carry
  // all the information whichever branch is taken.
  assign r_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/serial_div.sv
// Serial restoring divider: one quotient bit per clock, results held until
// the next accepted start.
module serial_div
  import serial_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsor;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r),
    .q       (q),
    .divisor (dsor),
    .r_next  (r_nxt),
    .q_next  (q_nxt)
  );

  assign last_step = (count == CW'(WIDTH - 1));
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      count       <= '0;
      r           <= '0;
      q           <= '0;
      dsor        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new start just like IDLE so operations can chain.
        S_IDLE, S_DONE: begin
          if (start) begin
            dsor  <= divisor;
            r     <= '0;
            q     <= dividend;
            count <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          r     <= r_nxt;
          q     <= q_nxt;
          count <= count + 1'b1;
          if (last_step) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
            state       <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
